// File: rtl/frame_gen_pkg.sv
// Shared types and constants for the frame traffic generator.
package frame_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_BODY,
    ST_TRL,
    ST_GAP,
    ST_FIN
  } state_e;

  localparam logic [1:0] PRIO_LOW  = 2'b00;
  localparam logic [1:0] PRIO_HIGH = 2'b01;
  localparam logic [1:0] PRIO_ALT  = 2'b10;

  // Wide enough for any practical DATA_W; users take the low DATA_W bits.
  localparam logic [63:0] HDR_BYTE = 64'h0;
  localparam logic [63:0] TRL_BYTE = '1;

  // Shortest legal frame: full header, full trailer and one body cycle.
  function automatic int unsigned min_frame_len(input int unsigned hdr_cyc,
                                                input int unsigned trl_cyc);
    return hdr_cyc + trl_cyc + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/frame_gen.sv
// Run-time configurable frame source: header/body/trailer frames with gap,
// priority modes, graceful stop, pause at frame boundaries and discard counting.
module frame_gen
  import frame_gen_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int LEN_W   = 12,
  parameter  int CNT_W   = 8,
  parameter  int HDR_CYC = 4,
  parameter  int TRL_CYC = 4,
  localparam int CTRL_W  = 2 * LEN_W
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  cfg_num,
  input  logic [LEN_W-1:0]  cfg_gap,
  input  logic [1:0]        cfg_prio_mode,
  input  logic              discard_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              ctrl_valid,
  output logic              hi_priority,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  discard_cnt
);

  localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(min_frame_len(HDR_CYC, TRL_CYC));
  localparam logic [LEN_W-1:0] HDR_LAST = LEN_W'(HDR_CYC - 1);
  localparam logic [LEN_W-1:0] TRL_LAST = LEN_W'(TRL_CYC - 1);
  localparam logic [LEN_W-1:0] BODY_ADJ = LEN_W'(HDR_CYC + TRL_CYC + 1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  seg_q, seg_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [1:0]        mode_q, mode_d;
  logic              stop_seen_q, stop_seen_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dv_q, dv_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              cv_q, cv_d;
  logic              hi_q, hi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_ok;
  logic              stop_any;
  logic              in_frame_d;

  // Next state and segment counter; seg_q holds remaining cycles minus one
  // in HDR/BODY/TRL, and remaining gap cycles in GAP.
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    len_d       = len_q;
    gap_d       = gap_q;
    num_d       = num_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    stop_seen_d = stop_seen_q;
    start_ok    = 1'b0;
    stop_any    = stop_seen_q | stop;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_ok    = 1'b1;
          state_d     = ST_HDR;
          seg_d       = HDR_LAST;
          len_d       = (cfg_len < MIN_LEN) ? MIN_LEN : cfg_len;
          gap_d       = cfg_gap;
          num_d       = cfg_num;
          mode_d      = cfg_prio_mode;
          frame_cnt_d = '0;
        end
      end
      ST_HDR: begin
        if (seg_q == '0) begin
          state_d = ST_BODY;
          seg_d   = len_q - BODY_ADJ;
        end else begin
          seg_d = seg_q - LEN_W'(1);
        end
      end
      ST_BODY: begin
        if (seg_q == '0) begin
          state_d = ST_TRL;
          seg_d   = TRL_LAST;
        end else begin
          seg_d = seg_q - LEN_W'(1);
        end
      end
      ST_TRL: begin
        if (seg_q == '0) begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          if (stop_any || ((num_q != '0) && (frame_cnt_d == num_q))) begin
            state_d = ST_FIN;
          end else if ((gap_q != '0) || pause) begin
            state_d = ST_GAP;
            seg_d   = gap_q;
          end else begin
            state_d = ST_HDR;
            seg_d   = HDR_LAST;
          end
        end else begin
          seg_d = seg_q - LEN_W'(1);
        end
      end
      ST_GAP: begin
        if (stop_any) begin
          state_d = ST_FIN;
        end else if (!pause) begin
          if (seg_q <= LEN_W'(1)) begin
            state_d = ST_HDR;
            seg_d   = HDR_LAST;
          end else begin
            seg_d = seg_q - LEN_W'(1);
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_FIN) || (state_d == ST_IDLE)) begin
      stop_seen_d = 1'b0;
    end else if (stop && (state_q != ST_IDLE)) begin
      stop_seen_d = 1'b1;
    end
  end

  // Outputs are registered and describe the cycle that state_d enters.
  // data_valid qualifies data_out every cycle; there is no back-pressure.
  always_comb begin
    in_frame_d = state_d inside {ST_HDR, ST_BODY, ST_TRL};
    cv_d       = (state_d == ST_HDR) && (state_q != ST_HDR);
    ctrl_d     = cv_d ? {len_d, len_d} : '0;
    dv_d       = in_frame_d;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_FIN);
    case (state_d)
      ST_HDR:  data_d = HDR_BYTE[DATA_W-1:0];
      ST_BODY: data_d = DATA_W'(frame_cnt_d);
      ST_TRL:  data_d = TRL_BYTE[DATA_W-1:0];
      default: data_d = '0;
    endcase
    // frame_cnt_d is the index of the frame being emitted, stable for its duration.
    case (mode_d)
      PRIO_HIGH: hi_d = in_frame_d;
      PRIO_ALT:  hi_d = in_frame_d & ~frame_cnt_d[0];
      default:   hi_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      seg_q       <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      num_q       <= '0;
      mode_q      <= PRIO_LOW;
      stop_seen_q <= 1'b0;
      frame_cnt_q <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      ctrl_q      <= '0;
      cv_q        <= 1'b0;
      hi_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      num_q       <= num_d;
      mode_q      <= mode_d;
      stop_seen_q <= stop_seen_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      ctrl_q      <= ctrl_d;
      cv_q        <= cv_d;
      hi_q        <= hi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_discard_cnt (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .clr   (start_ok),
    .inc   (discard_en & busy_q),
    .count (discard_cnt)
  );

  assign data_out    = data_q;
  assign data_valid  = dv_q;
  assign ctrl_out    = ctrl_q;
  assign ctrl_valid  = cv_q;
  assign hi_priority = hi_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_frame_gen.sv
// Directed bench for frame_gen: frame layout, priority modes, gap, stop,
// pause, configuration latching, discard saturation and async reset.
module tb_frame_gen;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 12;
  localparam int CNT_W  = 8;
  localparam int CTRL_W = 2 * LEN_W;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [CNT_W-1:0]  cfg_num = '0;
  logic [LEN_W-1:0]  cfg_gap = '0;
  logic [1:0]        cfg_prio_mode = '0;
  logic              discard_en = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [CTRL_W-1:0] ctrl_out;
  logic              ctrl_valid;
  logic              hi_priority;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  discard_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_sys = ~clk_sys;

  frame_gen dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .start         (start),
    .stop          (stop),
    .pause         (pause),
    .cfg_len       (cfg_len),
    .cfg_num       (cfg_num),
    .cfg_gap       (cfg_gap),
    .cfg_prio_mode (cfg_prio_mode),
    .discard_en    (discard_en),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .ctrl_out      (ctrl_out),
    .ctrl_valid    (ctrl_valid),
    .hi_priority   (hi_priority),
    .busy          (busy),
    .done          (done),
    .frame_cnt     (frame_cnt),
    .discard_cnt   (discard_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [63:0] obs();
    return {29'b0, ctrl_out, ctrl_valid, data_valid, hi_priority, data_out};
  endfunction

  function automatic logic [63:0] status();
    return {54'b0, done, busy, frame_cnt};
  endfunction

  task automatic start_run(input int len, input int num, input int gap, input int mode);
    cfg_len       = LEN_W'(len);
    cfg_num       = CNT_W'(num);
    cfg_gap       = LEN_W'(gap);
    cfg_prio_mode = 2'(mode);
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  // Checks one whole frame cycle by cycle, starting at its first header cycle.
  task automatic chk_frame(input int len, input int idx, input bit hi,
                           input int stop_at, input int pause_at);
    int              eff;
    logic [7:0]      b;
    logic [LEN_W-1:0] e12;
    logic [63:0]     exp;
    eff = (len < 9) ? 9 : len;
    e12 = LEN_W'(eff);
    for (int c = 0; c < eff; c++) begin
      if (c < 4) b = 8'h00;
      else if (c >= eff - 4) b = 8'hFF;
      else b = 8'(idx);
      exp = {29'b0, (c == 0) ? {e12, e12} : 24'h0, (c == 0), 1'b1, hi, b};
      check("frame", obs(), exp);
      stop = (c == stop_at);
      if (c == pause_at) pause = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    #1;
    check("reset_obs", obs(), 64'h0);
    check("reset_status", status(), 64'h0);
    check("reset_discard", 64'(discard_cnt), 64'h0);
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    tick();

    // Two back-to-back high-priority frames of 16, then done
    start_run(16, 2, 0, 1);
    chk_frame(16, 0, 1'b1, -1, -1);
    chk_frame(16, 1, 1'b1, -1, -1);
    check("t1_fin", status(), {54'b0, 1'b1, 1'b1, 8'd2});
    check("t1_discard", 64'(discard_cnt), 64'h0);
    tick();
    check("t1_idle", status(), {54'b0, 1'b0, 1'b0, 8'd2});

    // Short length clamps to 9; cfg changes and start mid-run are ignored
    start_run(5, 1, 0, 0);
    cfg_len       = LEN_W'(30);
    cfg_prio_mode = 2'b01;
    start         = 1'b1;
    chk_frame(5, 0, 1'b0, -1, -1);
    check("t2_fin", status(), {54'b0, 1'b1, 1'b1, 8'd1});
    tick();
    check("t2_idle", status(), {54'b0, 1'b0, 1'b0, 8'd1});

    // Alternating priority with a 3-cycle gap
    start_run(12, 3, 3, 2);
    for (int f = 0; f < 3; f++) begin
      chk_frame(12, f, (f % 2) == 0, -1, -1);
      if (f < 2) begin
        for (int g = 0; g < 3; g++) begin
          check("t3_gap", obs(), 64'h0);
          tick();
        end
      end
    end
    check("t3_fin", status(), {54'b0, 1'b1, 1'b1, 8'd3});
    tick();

    // Continuous run stopped mid frame 2
    start_run(10, 0, 0, 0);
    chk_frame(10, 0, 1'b0, -1, -1);
    chk_frame(10, 1, 1'b0, -1, -1);
    chk_frame(10, 2, 1'b0, 7, -1);
    check("t4_fin", status(), {54'b0, 1'b1, 1'b1, 8'd3});
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_quiet", obs(), 64'h0);
      check("t4_idle", status(), {54'b0, 1'b0, 1'b0, 8'd3});
      tick();
    end

    // Pause across a frame boundary with no gap
    start_run(9, 0, 0, 1);
    chk_frame(9, 0, 1'b1, -1, 5);
    for (int i = 0; i < 5; i++) begin
      check("t5_paused", obs(), 64'h0);
      check("t5_busy", status(), {54'b0, 1'b0, 1'b1, 8'd1});
      tick();
    end
    pause = 1'b0;
    check("t5_paused_last", obs(), 64'h0);
    tick();
    chk_frame(9, 1, 1'b1, 2, -1);
    check("t5_fin", status(), {54'b0, 1'b1, 1'b1, 8'd2});
    tick();

    // Discard counting, saturation, then async reset mid BODY
    start_run(16, 0, 0, 0);
    discard_en = 1'b1;
    repeat (3) tick();
    discard_en = 1'b0;
    check("t6_discard3", 64'(discard_cnt), 64'd3);
    discard_en = 1'b1;
    repeat (300) tick();
    discard_en = 1'b0;
    check("t6_discard_sat", 64'(discard_cnt), 64'd255);
    repeat (6) tick();
    check("t6_body", obs(), {29'b0, 24'h0, 1'b0, 1'b1, 1'b0, 8'h13});
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_obs", obs(), 64'h0);
    check("t6_rst_status", status(), 64'h0);
    check("t6_rst_discard", 64'(discard_cnt), 64'h0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_gen.md
Name: frame_gen

Overview:
- Synthesizable, parametrised frame traffic generator on the clk_sys domain; drives the receive-side interface of the transmit path (data bytes, data valid, frame control word, frame valid, priority).
- Replaces fixed-length, fixed-priority bench stimulus with a run-time configurable source:
  - frame length, frame count (or continuous), inter-frame gap, priority mode;
  - graceful stop and pause;
  - discard feedback counting.
- Used in-system for bring-up and throughput characterisation.

Parameters:
- DATA_W, 8, data byte width.
- LEN_W, 12, width of frame length, gap and length fields in the control word.
- CNT_W, 8, width of frame count and statistics counters.
- HDR_CYC, 4, header cycles per frame (data all-zeros).
- TRL_CYC, 4, trailer cycles per frame (data all-ones).
- CTRL_W (localparam), 2*LEN_W, control word width (24 at defaults).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- stop  in  1  request to end the run after the current frame completes.
- pause  in  1  level; holds the generator at a frame boundary.
- cfg_len  in  LEN_W  frame length in cycles.
- cfg_num  in  CNT_W  frames per run; 0 = continuous.
- cfg_gap  in  LEN_W  idle cycles between frames.
- cfg_prio_mode  in  2  00 low, 01 high, 10 alternate (frame 0 high), 11 treated as low.
- discard_en  in  1  discard indication from the transmit path.
- data_out  out  DATA_W  frame byte.
- data_valid  out  1  data_out valid.
- ctrl_out  out  CTRL_W  frame control word {len, len}.
- ctrl_valid  out  1  control word valid; first cycle of each frame only.
- hi_priority  out  1  frame priority; constant for the whole frame.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a run ends.
- frame_cnt  out  CNT_W  frames completed in the current run.
- discard_cnt  out  CNT_W  discard_en cycles counted in the current run; saturates.

Behaviour:
- Reset (asynchronous, takes effect immediately including mid-frame): state IDLE; all outputs 0, counters 0.
- Configuration:
  - cfg_* latched on an accepted start; later changes to cfg_* have no effect until the next run.
  - Effective length = max(cfg_len, HDR_CYC+TRL_CYC+1); values below 9 clamp to 9.
  - ctrl_out = {eff_len, eff_len}.
- On accepted start: frame_cnt and discard_cnt clear; first header cycle is the next cycle.
- FSM states: IDLE, HDR, BODY, TRL, GAP, FIN.
  - IDLE: on start -> HDR.
  - HDR: HDR_CYC cycles; data_out=0, data_valid=1. ctrl_valid=1 with ctrl_out on the first cycle only; otherwise ctrl_valid=0 and ctrl_out=0.
  - BODY: eff_len-HDR_CYC-TRL_CYC cycles; data_out = frame index mod 2^DATA_W; data_valid=1.
  - TRL: TRL_CYC cycles; data_out = all ones; data_valid=1.
  - End of the last TRL cycle: frame_cnt increments (wraps). Next state:
    - FIN if stop has been seen since the frame began, or cfg_num≠0 and the new count equals cfg_num;
    - else GAP if cfg_gap≠0 or pause=1;
    - else HDR (back-to-back frames).
  - GAP: data_valid=0, data_out=0. Exits to HDR after cfg_gap cycles with pause=0; pause=1 freezes the gap counter. Stop seen in GAP -> FIN.
  - FIN: done=1 for one cycle -> IDLE.
- Stop and pause:
  - stop is sticky until FIN; stop in IDLE is ignored.
  - A frame in progress always completes; pause never splits a frame.
  - start while busy is ignored.
- Priority:
  - hi_priority is set at the first HDR cycle and held through TRL.
  - Mode 10: hi_priority = ~frame_index[0].
  - Outside frames hi_priority is 0.
- discard_cnt: increments on each cycle with discard_en=1 while busy; saturates at all ones.
- Frame index: counts frames since start; equal to frame_cnt at HDR entry.
- Frame period = eff_len + cfg_gap cycles, with no pause.

Decomposition:
- Shared package frame_gen_pkg:
  - state enumeration;
  - priority mode codes;
  - HDR_BYTE (0) and TRL_BYTE (all ones) constants;
  - minimum-length function.
- One natural sub-module: sat_counter (parametrised width, clear, increment, saturate), used for discard_cnt.
- The segment down-counter stays in frame_gen.

Test Plan:
- cfg_len=16, cfg_num=2, cfg_gap=0, mode 01, start -> next cycle ctrl_out=24'h010010 with ctrl_valid=1 for 1 cycle, then:
  - 4×00, 8×00, 4×FF with hi_priority=1;
  - immediately followed by 4×00, 8×01, 4×FF;
  - done pulse 1 cycle after the last FF; frame_cnt=2.
- cfg_len=5 -> frames are 9 cycles long (4×00, 1×body, 4×FF); ctrl_out=24'h009009.
- cfg_len=12, cfg_gap=3, cfg_num=3, mode 10 -> data_valid low exactly 3 cycles between frames; hi_priority 1,0,1.
- cfg_num=0, stop pulsed at cycle 7 of frame 2 (frame index 2) -> frame 2 completes fully, done pulses, no further ctrl_valid.
- pause high across a frame boundary with cfg_gap=0 -> current frame completes; data_valid stays 0 while pause=1; next frame resumes with the next index.
- reset_n low during BODY -> all outputs 0 immediately. discard_en held 300 cycles with CNT_W=8 -> discard_cnt=255.
